debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer: N_CH independent inputs (switches/keys), each synchronised, debounced with a per-channel counter, and given registered edge and long-press/auto-repeat event pulses.
- Sits between board pins and the control FSMs. Downstream logic consumes single-cycle events rather than detecting edges itself.
- Timing is expressed in ns and converted to cycles at elaboration. Per-channel counters are used (no shared timer), so channels never interfere.

Parameters:
- N_CH, 4, number of independent channels.
- CLK_PERIOD_ns, 20, clock period.
- DEBOUNCE_TIMER_ns, 30_000_000, required stable time before the output follows the input.
- SYNC_STAGES, 2, synchroniser depth per channel. Minimum 2.
- HOLD_TIMER_ns, 1_000_000_000, time sig_o must stay high before the first hold_o pulse.
- REPEAT_EN, 0, 1 enables auto-repeat hold_o pulses after the first.
- REPEAT_TIMER_ns, 200_000_000, spacing of auto-repeat pulses.
- Derived values:
  - DB_CYCLES = max(1, DEBOUNCE_TIMER_ns/CLK_PERIOD_ns − SYNC_STAGES)
  - HOLD_CYCLES = HOLD_TIMER_ns/CLK_PERIOD_ns
  - REP_CYCLES = REPEAT_TIMER_ns/CLK_PERIOD_ns
  - Counter widths = $clog2(max cycles + 1).

Ports:
- clk, input, 1, system clock. Single clock domain.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, clock enable for debounce, hold and repeat logic.
- sig_i, input, N_CH, raw asynchronous inputs.
- sig_o, output, N_CH, debounced levels.
- rise_o, output, N_CH, one-cycle pulse on a sig_o 0→1 transition.
- fall_o, output, N_CH, one-cycle pulse on a sig_o 1→0 transition.
- hold_o, output, N_CH, one-cycle long-press / auto-repeat pulse.

Behaviour:
- Reset: while reset is high, all synchroniser flops, sig_o, rise_o, fall_o, hold_o, db_cnt and hold_cnt are 0. Reset is asserted asynchronously and is honoured mid-count: an in-progress debounce is discarded.
- Synchroniser: SYNC_STAGES flops per channel, clocked every cycle regardless of enable. Output is s_sync[i].
- Debounce, per channel i, on an enabled cycle:
  - If s_sync == sig_o: db_cnt ← 0.
  - Else if db_cnt == DB_CYCLES−1: sig_o ← s_sync and db_cnt ← 0.
  - Else: db_cnt ← db_cnt + 1.
- Latency: sig_o changes exactly SYNC_STAGES + DB_CYCLES enabled rising edges after the first edge that samples the new sig_i level.
- Glitch rejection: any input change whose synchronised duration is < DB_CYCLES cycles never reaches sig_o. The counter restarts from 0 on each bounce back to the current sig_o level.
- Edge pulses:
  - rise_o/fall_o are registered and high during the first cycle sig_o holds its new value. They are low otherwise.
  - Both are never high together on a channel.
- Hold counter, per channel:
  - hold_cnt ← 0 whenever sig_o == 0.
  - While sig_o == 1 and enable, hold_cnt increments.
  - hold_o pulses for one cycle in the cycle when hold_cnt reaches HOLD_CYCLES.
  - REPEAT_EN=0: hold_cnt saturates at HOLD_CYCLES and no further pulses occur until release.
  - REPEAT_EN=1: after the first pulse, hold_cnt reloads to HOLD_CYCLES−REP_CYCLES, giving a pulse every REP_CYCLES cycles while held.
  - Release (fall) clears hold_cnt immediately. No hold_o is issued in the fall cycle.
- enable low:
  - db_cnt, hold_cnt and sig_o are frozen.
  - rise_o, fall_o and hold_o are forced to 0 in that cycle.
  - The synchroniser keeps sampling.
  - On re-enable, counting resumes from the frozen values.
- Simultaneous events: channels are fully independent. Any subset of rise, fall and hold pulses may fire across channels in the same cycle.
- Widths: no counter overflows. All counters saturate or reset as defined above.

Test Plan:
- Common sim configuration: CLK_PERIOD_ns=10, DEBOUNCE_TIMER_ns=100 (DB_CYCLES=8), HOLD_TIMER_ns=300 (HOLD_CYCLES=30), REP 100 (REP_CYCLES=10), N_CH=4.
- Clean press: sig_i[0] 0→1 held → sig_o[0]=1 exactly 10 edges after the first sampling edge, rise_o[0] high 1 cycle. Other channels stay 0.
- Bounce: sig_i[1] toggles with 3-cycle high/low for 40 cycles, then stable high → no rise_o during bouncing; sig_o[1] rises 10 edges after the last transition.
- Glitch: 7-cycle high pulse on sig_i[2] → sig_o[2] stays 0. 8-cycle pulse → sig_o[2] rises, then falls 10 edges after the input drop, fall_o[2] high 1 cycle.
- Long press with REPEAT_EN=0: hold sig_o[3]=1 for 100 cycles → hold_o[3] exactly once, 30 cycles after the rise. With REPEAT_EN=1: hold_o at +30, +40, +50, … until release. No pulse after release.
- Enable gating: drop enable for 20 cycles mid-debounce (db_cnt=4) → sig_o is unchanged and no pulses occur; after re-enable, sig_o changes 4 enabled cycles later.
- Async reset mid-count: assert reset between clock edges with sig_o=1 and hold_cnt=15 → all outputs 0 immediately. After release with sig_i still high → rise_o again after 10 edges.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, debouncer and registered rise/fall/long-press event generator
module debounce_multi #(
    parameter int N_CH              = 4,
    parameter int CLK_PERIOD_ns     = 20,
    parameter int DEBOUNCE_TIMER_ns = 30_000_000,
    parameter int SYNC_STAGES       = 2,
    parameter int HOLD_TIMER_ns     = 1_000_000_000,
    parameter int REPEAT_EN         = 0,
    parameter int REPEAT_TIMER_ns   = 200_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] sig_i,
    output logic [N_CH-1:0] sig_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] hold_o
);
    localparam int DB_RAW      = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns - SYNC_STAGES;
    localparam int DB_CYCLES   = DB_RAW < 1 ? 1 : DB_RAW;
    localparam int HOLD_CYCLES = HOLD_TIMER_ns / CLK_PERIOD_ns;
    localparam int REP_CYCLES  = REPEAT_TIMER_ns / CLK_PERIOD_ns;
    // repeat spacing longer than the first hold simply repeats at the hold period
    localparam int RELOAD      = REP_CYCLES >= HOLD_CYCLES ? 0 : HOLD_CYCLES - REP_CYCLES;
    localparam int DBW         = $clog2(DB_CYCLES + 1);
    localparam int HW          = $clog2(HOLD_CYCLES + 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= sig_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic           so_q, so_d, rise_q, rise_d, fall_q, fall_d, hold_q, hold_d, diff, last;
        logic [DBW-1:0] db_q, db_d;
        logic [HW-1:0]  hc_q, hc_d;

        always_comb begin
            diff   = s_sync[c] ^ so_q;
            last   = db_q == DBW'(DB_CYCLES - 1);
            so_d   = enable && diff && last ? s_sync[c] : so_q;
            db_d   = !enable ? db_q : (!diff || last) ? '0 : db_q + DBW'(1);
            rise_d = !so_q && so_d;
            fall_d = so_q && !so_d;
            hold_d = enable && so_q && !fall_d && hc_q == HW'(HOLD_CYCLES - 1);
            hc_d   = (!so_q || fall_d) ? '0 :
                     !enable ? hc_q :
                     hold_d ? HW'(REPEAT_EN != 0 ? RELOAD : HOLD_CYCLES) :
                     hc_q == HW'(HOLD_CYCLES) ? hc_q : hc_q + HW'(1);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                so_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                hold_q <= 1'b0;
                db_q   <= '0;
                hc_q   <= '0;
            end else begin
                so_q   <= so_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                hold_q <= hold_d;
                db_q   <= db_d;
                hc_q   <= hc_d;
            end
        end

        assign sig_o[c]  = so_q;
        assign rise_o[c] = rise_q;
        assign fall_o[c] = fall_q;
        assign hold_o[c] = hold_q;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: scoreboard bench driving a non-repeating and a repeating instance from one stimulus stream
module tb_debounce_multi;
    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int HOLD = 30;
    localparam int REP  = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic [N-1:0] sig_i = '0;
    logic [N-1:0] so0, ri0, fa0, ho0, so1, ri1, fa1, ho1;

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(N), .CLK_PERIOD_ns(10), .DEBOUNCE_TIMER_ns(100), .SYNC_STAGES(SYNC),
                     .HOLD_TIMER_ns(300), .REPEAT_EN(0), .REPEAT_TIMER_ns(100)) u_norep (
        .clk(clk), .reset(reset), .enable(enable), .sig_i(sig_i),
        .sig_o(so0), .rise_o(ri0), .fall_o(fa0), .hold_o(ho0));

    debounce_multi #(.N_CH(N), .CLK_PERIOD_ns(10), .DEBOUNCE_TIMER_ns(100), .SYNC_STAGES(SYNC),
                     .HOLD_TIMER_ns(300), .REPEAT_EN(1), .REPEAT_TIMER_ns(100)) u_rep (
        .clk(clk), .reset(reset), .enable(enable), .sig_i(sig_i),
        .sig_o(so1), .rise_o(ri1), .fall_o(fa1), .hold_o(ho1));

    // reference model: raw sample history, timestamps in enabled-edge units
    logic [N-1:0] rawq [$];
    logic [N-1:0] mso [2];
    logic [N-1:0] er [2];
    logic [N-1:0] ef [2];
    logic [N-1:0] eh [2];
    int           since [2][N];
    int           rise_n [2][N];
    int           n_en = 0;
    logic [31:0]  expq [$];
    logic [31:0]  mon_e;
    int           tests = 0;
    int           fails = 0;

    task automatic model_reset();
        rawq.delete();
        repeat (SYNC) rawq.push_back('0);
        for (int r = 0; r < 2; r++) begin
            mso[r] = '0; er[r] = '0; ef[r] = '0; eh[r] = '0;
            for (int c = 0; c < N; c++) since[r][c] = -1;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        logic         old;
        int           k;
        s = rawq[0];
        for (int r = 0; r < 2; r++) begin er[r] = '0; ef[r] = '0; eh[r] = '0; end
        if (reset) model_reset();
        else begin
            void'(rawq.pop_front());
            rawq.push_back(sig_i);
            if (enable) begin
                n_en++;
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < N; c++) begin
                        old = mso[r][c];
                        if (s[c] == mso[r][c]) since[r][c] = -1;
                        else begin
                            if (since[r][c] < 0) since[r][c] = n_en;
                            if (n_en - since[r][c] + 1 >= DB) begin
                                mso[r][c] = s[c];
                                since[r][c] = -1;
                            end
                        end
                        if (!old && mso[r][c]) begin er[r][c] = 1'b1; rise_n[r][c] = n_en; end
                        if (old && !mso[r][c]) ef[r][c] = 1'b1;
                        if (old && mso[r][c]) begin
                            k = n_en - rise_n[r][c];
                            eh[r][c] = k == HOLD || (r == 1 && k > HOLD && (k - HOLD) % REP == 0);
                        end
                    end
            end
        end
    endtask

    task automatic tick(input bit nr, input bit ne, input logic [N-1:0] ns);
        @(posedge clk);
        #1;
        model_step();
        if (nr) model_reset();
        reset = nr;
        expq.push_back({mso[0], er[0], ef[0], eh[0], mso[1], er[1], ef[1], eh[1]});
        enable = ne;
        sig_i = ns;
    endtask

    task automatic run(input int n, input logic [N-1:0] s, input bit en = 1'b1);
        for (int i = 0; i < n; i++) tick(1'b0, en, s);
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("sig_norep",  so0, mon_e[31:28]);
            check("rise_norep", ri0, mon_e[27:24]);
            check("fall_norep", fa0, mon_e[23:20]);
            check("hold_norep", ho0, mon_e[19:16]);
            check("sig_rep",    so1, mon_e[15:12]);
            check("rise_rep",   ri1, mon_e[11:8]);
            check("fall_rep",   fa1, mon_e[7:4]);
            check("hold_rep",   ho1, mon_e[3:0]);
        end
    end

    initial begin
        logic [N-1:0] ns;
        int           rate [N];
        model_reset();
        repeat (3) tick(1'b1, 1'b1, '0);
        run(20, 4'b0000);
        run(25, 4'b0001);
        for (int i = 0; i < 14; i++) run(3, (i % 2) ? 4'b0001 : 4'b0011);
        run(25, 4'b0011);
        run(7, 4'b0111);
        run(25, 4'b0011);
        run(8, 4'b0111);
        run(30, 4'b0011);
        run(100, 4'b1011);
        run(40, 4'b0011);
        run(6, 4'b0010);
        run(20, 4'b0010, 1'b0);
        run(20, 4'b0010);
        run(25, 4'b1010);
        tick(1'b1, 1'b1, 4'b1010);
        tick(1'b1, 1'b1, 4'b1010);
        tick(1'b0, 1'b1, 4'b1010);
        run(40, 4'b1010);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < N; c++) rate[c] = $urandom_range(2, 120);
            for (int i = 0; i < 500; i++) begin
                ns = sig_i;
                for (int c = 0; c < N; c++) if ($urandom_range(0, rate[c]) == 0) ns[c] = ~ns[c];
                tick($urandom_range(0, 999) == 0, $urandom_range(0, 19) != 0, ns);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
